gpio_ip: RTL and testbench

Memory-mapped general-purpose I/O block with a 32-bit register interface. It holds per-pin output data and direction registers, drives output pins, and samples input pins for readback. It sits on the simple peripheral bus beside the other register-mapped IPs.

---
 rtl/gpio_ip_pkg.sv | 13 +
 rtl/gpio_sync.sv | 26 ++
 rtl/gpio_ip.sv | 87 ++++++++
 tb/tb_gpio_ip.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_ip_pkg.sv
// Shared constants for the gpio_ip register block: register word width
// and the byte offsets of every register in the map.
package gpio_ip_pkg;

  localparam int REG_W = 32;

  localparam logic [7:0] GPIO_ADDR_DATA = 8'h00;
  localparam logic [7:0] GPIO_ADDR_DIR  = 8'h04;
  localparam logic [7:0] GPIO_ADDR_IN   = 8'h08;
  localparam logic [7:0] GPIO_ADDR_SET  = 8'h0C;
  localparam logic [7:0] GPIO_ADDR_CLR  = 8'h10;

endpackage

// File: rtl/gpio_sync.sv
// Vector 2-flop synchronizer for the asynchronous pin inputs.
// Both stages reset to 0. Each bit is synchronized independently, so a
// multi-bit change may land on different cycles per bit.
module gpio_sync #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops; q is the second (settled) stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gpio_ip.sv
// gpio_ip: memory-mapped GPIO with DATA, DIR, IN, SET and CLR registers.
// Optional build macro GPIO_IN_SYNC_EN: when defined, gpio_in is passed
// through gpio_sync (2-cycle input latency); otherwise it is registered
// once (1-cycle latency).
//
// Bus protocol: no handshake and no wait states. wr_en high for a cycle
// performs exactly one write at that rising edge; rd_en high for a cycle
// performs one read whose data appears on rdata after that edge and is
// held until the next read. Strobes may be asserted every cycle, and a
// read and write in the same cycle see the pre-write register value.
module gpio_ip
  import gpio_ip_pkg::*;
#(
  parameter int GPIO_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [7:0]       addr,
  input  logic [REG_W-1:0] wdata,
  output logic [REG_W-1:0] rdata,
  input  logic [REG_W-1:0] gpio_in,
  output logic [REG_W-1:0] gpio_out
);

  // Bits at and above GPIO_W are never stored, so they always read 0.
  localparam logic [REG_W-1:0] PIN_MASK = {REG_W{1'b1}} >> (REG_W - GPIO_W);

  logic [REG_W-1:0] data_q;
  logic [REG_W-1:0] dir_q;
  logic [REG_W-1:0] in_q;
  logic [REG_W-1:0] rd_word;

`ifdef GPIO_IN_SYNC_EN
  // The synchronizer's second stage doubles as the IN register, which
  // keeps the input latency at two edges.
  gpio_sync #(.W(REG_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpio_in & PIN_MASK),
    .q   (in_q)
  );
`else
  // Single register stage straight from the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_q <= '0;
    else     in_q <= gpio_in & PIN_MASK;
  end
`endif

  // DATA and DIR updates; writes to IN or unmapped offsets fall through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      dir_q  <= '0;
    end else if (wr_en) begin
      case (addr)
        GPIO_ADDR_DATA: data_q <= wdata & PIN_MASK;
        GPIO_ADDR_DIR:  dir_q  <= wdata & PIN_MASK;
        GPIO_ADDR_SET:  data_q <= data_q | (wdata & PIN_MASK);
        GPIO_ADDR_CLR:  data_q <= data_q & ~wdata;
        default:        ;
      endcase
    end
  end

  // Read mux; write-only and unmapped offsets return 0.
  always_comb begin
    rd_word = '0;
    case (addr)
      GPIO_ADDR_DATA: rd_word = data_q;
      GPIO_ADDR_DIR:  rd_word = dir_q;
      GPIO_ADDR_IN:   rd_word = in_q;
      default:        rd_word = '0;
    endcase
  end

  // Registered read data, held while rd_en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdata <= '0;
    else if (rd_en) rdata <= rd_word;
  end

  assign gpio_out = data_q & dir_q;

endmodule

// File: tb/tb_gpio_ip.sv
// Directed self-checking bench for gpio_ip.
module tb_gpio_ip;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;

  int checks;
  int failures;

`ifdef GPIO_IN_SYNC_EN
  localparam int IN_LAT = 2;
`else
  localparam int IN_LAT = 1;
`endif

  gpio_ip dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: drive after a falling edge, sample on the next falling edge.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    rd_en = 1'b1;
    addr  = a;
    @(negedge clk);
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    gpio_in = 32'hA5A5_A5A5;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (gpio_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_gpio_out_during actual=%h required=%h", gpio_out, 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (gpio_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_gpio_out_after actual=%h required=%h", gpio_out, 32'h0);
    end
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata actual=%h required=%h", rdata, 32'h0);
    end
    do_read(8'h00, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reset_data_reg actual=%h required=%h", d, 32'h0);
    end
  endtask

  task automatic test_data_dir();
    logic [31:0] d;
    do_write(8'h04, 32'h0000_00FF);
    do_write(8'h00, 32'h0000_00AA);
    checks++;
    if (gpio_out !== 32'h0000_00AA) begin
      failures++;
      $display("FAIL data_dir_gpio_out actual=%h required=%h", gpio_out, 32'h0000_00AA);
    end
    do_read(8'h00, d);
    checks++;
    if (d !== 32'h0000_00AA) begin
      failures++;
      $display("FAIL read_data actual=%h required=%h", d, 32'h0000_00AA);
    end
    do_read(8'h04, d);
    checks++;
    if (d !== 32'h0000_00FF) begin
      failures++;
      $display("FAIL read_dir actual=%h required=%h", d, 32'h0000_00FF);
    end
    // rdata must hold while rd_en stays low
    repeat (2) @(negedge clk);
    checks++;
    if (rdata !== 32'h0000_00FF) begin
      failures++;
      $display("FAIL rdata_hold actual=%h required=%h", rdata, 32'h0000_00FF);
    end
  endtask

  task automatic test_input();
    logic [31:0] d;
    logic [31:0] exp;
    do_read(8'h08, d);
    checks++;
    if (d !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL in_static actual=%h required=%h", d, 32'hA5A5_A5A5);
    end
    // Change the pins and read on every edge: rdata at edge k shows IN as
    // it stood before edge k, so the new value appears at edge IN_LAT+1.
    @(negedge clk);
    gpio_in = 32'h1234_5678;
    rd_en   = 1'b1;
    addr    = 8'h08;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp = (k >= IN_LAT + 1) ? 32'h1234_5678 : 32'hA5A5_A5A5;
      checks++;
      if (rdata !== exp) begin
        failures++;
        $display("FAIL in_latency_edge%0d actual=%h required=%h", k, rdata, exp);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_set_clr();
    logic [31:0] d;
    do_write(8'h04, 32'h0000_00FF);
    do_write(8'h00, 32'hFFFF_FFFF);
    checks++;
    if (gpio_out !== 32'h0000_00FF) begin
      failures++;
      $display("FAIL masked_out actual=%h required=%h", gpio_out, 32'h0000_00FF);
    end
    do_write(8'h0C, 32'h0000_0100);
    do_write(8'h10, 32'h0000_000F);
    do_read(8'h00, d);
    checks++;
    if (d !== 32'hFFFF_FFF0) begin
      failures++;
      $display("FAIL set_clr_data actual=%h required=%h", d, 32'hFFFF_FFF0);
    end
    checks++;
    if (gpio_out !== 32'h0000_00F0) begin
      failures++;
      $display("FAIL set_clr_out actual=%h required=%h", gpio_out, 32'h0000_00F0);
    end
    do_read(8'h0C, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL read_set actual=%h required=%h", d, 32'h0);
    end
    do_read(8'h10, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL read_clr actual=%h required=%h", d, 32'h0);
    end
  endtask

  task automatic test_rw_same_cycle();
    logic [31:0] d;
    do_write(8'h00, 32'h0000_00AA);
    @(negedge clk);
    rd_en = 1'b1;
    wr_en = 1'b1;
    addr  = 8'h00;
    wdata = 32'h0000_0055;
    @(negedge clk);
    rd_en = 1'b0;
    wr_en = 1'b0;
    checks++;
    if (rdata !== 32'h0000_00AA) begin
      failures++;
      $display("FAIL rw_old_value actual=%h required=%h", rdata, 32'h0000_00AA);
    end
    do_read(8'h00, d);
    checks++;
    if (d !== 32'h0000_0055) begin
      failures++;
      $display("FAIL rw_new_value actual=%h required=%h", d, 32'h0000_0055);
    end
    do_write(8'h08, 32'hFFFF_FFFF);
    do_read(8'h00, d);
    checks++;
    if (d !== 32'h0000_0055) begin
      failures++;
      $display("FAIL in_write_data actual=%h required=%h", d, 32'h0000_0055);
    end
    do_read(8'h04, d);
    checks++;
    if (d !== 32'h0000_00FF) begin
      failures++;
      $display("FAIL in_write_dir actual=%h required=%h", d, 32'h0000_00FF);
    end
    do_read(8'h08, d);
    checks++;
    if (d !== 32'h1234_5678) begin
      failures++;
      $display("FAIL in_write_in actual=%h required=%h", d, 32'h1234_5678);
    end
    // Rerun the unmapped read with a nonzero rdata beforehand
    do_read(8'h20, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL unmapped_read actual=%h required=%h", d, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    // DATA write, SET, then read on three consecutive edges
    @(negedge clk);
    wr_en = 1'b1; addr = 8'h00; wdata = 32'h0000_0001;
    @(negedge clk);
    addr = 8'h0C; wdata = 32'h0000_0002;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1; addr = 8'h00;
    @(negedge clk);
    rd_en = 1'b0;
    checks++;
    if (rdata !== 32'h0000_0003) begin
      failures++;
      $display("FAIL back_to_back actual=%h required=%h", rdata, 32'h0000_0003);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    do_write(8'h04, 32'h0000_00FF);
    do_write(8'h00, 32'h0000_00AA);
    gpio_in = 32'h0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (gpio_out !== 32'h0) begin
      failures++;
      $display("FAIL async_reset_out actual=%h required=%h", gpio_out, 32'h0);
    end
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL async_reset_rdata actual=%h required=%h", rdata, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    do_read(8'h00, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL post_reset_data actual=%h required=%h", d, 32'h0);
    end
    do_read(8'h04, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL post_reset_dir actual=%h required=%h", d, 32'h0);
    end
    do_read(8'h08, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL post_reset_in actual=%h required=%h", d, 32'h0);
    end
  endtask

  // Test sequence and final report
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    addr     = 8'h00;
    wdata    = 32'h0;
    gpio_in  = 32'h0;
    test_reset();
    test_data_dir();
    test_input();
    test_set_clr();
    test_rw_same_cycle();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
